// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: architectural word width and register-file geometry.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file: zero-register forcing,
// optional same-cycle write forwarding, and the rdata/rvalid output flops.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    assign w_zero = (i_raddr == ADDR_W'(REG_ZERO));
    assign w_hit  = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

    always_comb begin
        w_next = i_mem_rdata;
        if (w_zero) begin
            w_next = '0;
        end else if (w_hit) begin
            w_next = i_wdata;
        end
    end

    // o_rvalid pulses for exactly one cycle per accepted request; there is no
    // ready/back-pressure, so every request is consumed on the edge it is seen.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) begin
                r_rdata <= w_next;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/regfile_2r1w.sv
// General-purpose register file: one synchronous write port and two
// independent registered read ports; register 0 always reads as zero.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam int NUM = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NUM];
    logic [DATA_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_mem_b;

    // Word 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign w_mem_a = r_mem[raddr_a];
    assign w_mem_b = r_mem[raddr_b];

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_a (
        .clk         (clk),
        .srst_n      (srst_n),
        .i_re        (re_a),
        .i_raddr     (raddr_a),
        .i_mem_rdata (w_mem_a),
        .i_we        (we),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .o_rdata     (rdata_a),
        .o_rvalid    (rvalid_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_b (
        .clk         (clk),
        .srst_n      (srst_n),
        .i_re        (re_b),
        .i_raddr     (raddr_b),
        .i_mem_rdata (w_mem_b),
        .i_we        (we),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .o_rdata     (rdata_b),
        .o_rvalid    (rvalid_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a word-array reference model predicts
// each port's {rvalid, rdata} per edge; a monitor pops and compares.
module tb_regfile_2r1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int BYPASS = 1;

    logic              clk;
    logic              srst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic              rvalid_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid_b;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) dut (
        .clk      (clk),
        .srst_n   (srst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .rvalid_a (rvalid_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .rvalid_b (rvalid_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DATA_W-1:0] model_mem [NREG];
    logic [DATA_W-1:0] last_a;
    logic [DATA_W-1:0] last_b;
    logic [DATA_W:0]   exp_a_q [$];   // {rvalid, rdata}
    logic [DATA_W:0]   exp_b_q [$];
    int                checks;
    int                errors;
    bit                started;

    function automatic logic [DATA_W-1:0] predict(input logic [ADDR_W-1:0] ra,
                                                  input logic w, input logic [ADDR_W-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
        if (ra == 0) return '0;
        if (BYPASS != 0 && w && wa == ra) return wd;
        return model_mem[ra];
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic rst_n, input logic w, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic ea, input logic [ADDR_W-1:0] ra,
                         input logic eb, input logic [ADDR_W-1:0] rb);
        @(negedge clk);
        srst_n = rst_n; we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) model_mem[i] = '0;
            last_a = '0;
            last_b = '0;
            exp_a_q.push_back({1'b0, last_a});
            exp_b_q.push_back({1'b0, last_b});
        end else begin
            if (ea) last_a = predict(ra, w, wa, wd);
            if (eb) last_b = predict(rb, w, wa, wd);
            exp_a_q.push_back({ea, last_a});
            exp_b_q.push_back({eb, last_b});
            if (w && wa != 0) model_mem[wa] = wd;
        end
        started = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [DATA_W:0] e;
        #1;
        if (started) begin
            if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
            end else begin
                e = exp_a_q.pop_front();
                check("rvalid_a", {31'd0, rvalid_a}, {31'd0, e[DATA_W]});
                check("rdata_a", rdata_a, e[DATA_W-1:0]);
                e = exp_b_q.pop_front();
                check("rvalid_b", {31'd0, rvalid_b}, {31'd0, e[DATA_W]});
                check("rdata_b", rdata_b, e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0; started = 1'b0;
        srst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
        last_a = '0; last_b = '0;
        for (int i = 0; i < NREG; i++) model_mem[i] = '0;

        // reset clear: two reset edges, then every address reads zero
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < NREG; i++) cycle(1'b1, 1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b0, '0);

        // write then read next edge
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd5);

        // zero register ignores writes
        cycle(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);

        // bypass collision on both ports
        cycle(1'b1, 1'b1, 5'd7, 32'h11111111, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7);
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7);

        // hold while idle and rvalid low
        cycle(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0);
        cycle(1'b1, 1'b1, 5'd3, 32'h5A5A5A5A, 1'b0, '0, 1'b0, '0);
        idle();
        idle();
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3);

        // reset mid-stream with a concurrent write and read
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, 1'b1, ADDR_W'(i), $urandom, 1'b1, ADDR_W'(i - 1), 1'b1, ADDR_W'(i));
        end
        cycle(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd2);
        for (int i = 0; i < NREG; i++) cycle(1'b1, 1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(NREG - 1 - i));

        // randomized traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 600; n++) begin
            logic [ADDR_W-1:0] wa, ra, rb;
            wa = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            rb = ($urandom_range(0, 1) == 0) ? wa : ADDR_W'($urandom_range(0, 7));
            cycle(($urandom_range(0, 79) != 0), 1'($urandom), wa, $urandom,
                  1'($urandom), ra, 1'($urandom), rb);
        end

        @(posedge clk);
        #2;
        started = 1'b0;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp_a_q.size(), exp_b_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

General-purpose register file for the CPU datapath: 2^ADDR_W words of DATA_W bits, one synchronous write port and two independent registered read ports (A and B). It sits between decode, which issues rs1/rs2 reads, and writeback, which issues the rd write. Address 0 is hardwired to zero. An optional write-to-read bypass lets a read issued in the same cycle as a write to the same address return the new data.

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns the pre-write value

- clk  input  1  clock; all state updates on the rising edge
- srst_n  input  1  reset, synchronous and active-low
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- re_a  input  1  read request, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  DATA_W  registered read data, port A
- rvalid_a  output  1  rdata_a was updated by a request in the previous cycle
- re_b  input  1  read request, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  DATA_W  registered read data, port B
- rvalid_b  output  1  rdata_b was updated by a request in the previous cycle

## Operation
- **Reset:** a rising edge with srst_n=0 does all of the following:
  - clears every storage word to 0;
  - sets rdata_a, rdata_b = 0 and rvalid_a, rvalid_b = 0;
  - ignores we, re_a and re_b in that cycle.
- **Write:** a rising edge with srst_n=1, we=1 and waddr≠0 sets mem[waddr] <= wdata.
  - A write to address 0 is discarded, with no side effect.
- **Read, per port x ∈ {a,b}, rising edge with srst_n=1 and re_x=1:**
  - if raddr_x=0: rdata_x <= 0;
  - else if BYPASS=1, we=1 and waddr=raddr_x: rdata_x <= wdata;
  - else: rdata_x <= mem[raddr_x], the value before this edge's write;
  - in every case rvalid_x <= 1.
- **No read request (re_x=0):** rdata_x holds its value and rvalid_x <= 0.
- **Independent ports:** A and B work independently.
  - Both may read the same address in the same cycle and get identical data.
  - Both may also collide with the write address; the bypass applies to each port separately.
- **No stalls or back-pressure:** every request completes.

## Timing
- Read latency is 1 cycle: request at edge N, data and rvalid valid after edge N, usable in cycle N+1.
- A write at edge N is visible to any read requested at edge N+1 or later, regardless of BYPASS.
- For a read requested at edge N to the address written at edge N:
  - BYPASS=1 returns the new data;
  - BYPASS=0 returns the old data.
- Back-to-back reads on the same port are allowed every cycle; rvalid_x stays high for consecutive requests.
- **Reset mid-operation:** a read requested in the reset cycle produces rvalid_x=0 and rdata_x=0.
  - The first request after srst_n returns high reads 0 from every address until that address is written.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package cpu_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the zero-register index constant REG_ZERO=0.
- The parameter defaults are taken from cpu_pkg.
- Storage is a single array owned by the top module; write logic and reset clearing also live in the top.
- Sub-module rf_read_port is instantiated twice (A and B). It contains:
  - the zero-address check;
  - the bypass compare;
  - the rdata/rvalid output flops.
- rf_read_port takes the mem read value, the write-port signals and its own re/raddr, plus clk/srst_n.

## Test plan
- **Reset clear:** reset 2 cycles, then re_a=1 on each of addresses 0..31 in turn -> rdata_a=0x00000000 every time; rvalid_a=1 one cycle after each request.
- **Write then read:** write 0xDEADBEEF to addr 5 at edge N, re_a=1/raddr_a=5 at edge N+1 -> rdata_a=0xDEADBEEF, rvalid_a=1 after N+1.
- **Zero register:** write 0x12345678 to addr 0, then read addr 0 on both ports -> rdata_a=rdata_b=0.
- **Bypass:** addr 7 holds 0x11111111; at one edge write 0x22222222 to addr 7 and read addr 7 on both ports -> BYPASS=1 gives 0x22222222 on both ports; BYPASS=0 gives 0x11111111 on both.
- **Hold and valid:** read addr 3 (0xA5A5A5A5), then re_a=0 for 3 cycles while addr 3 is rewritten to 0x5A5A5A5A -> rdata_a stays 0xA5A5A5A5 and rvalid_a=0 for those cycles.
- **Reset mid-stream:** alternate writes and dual reads, assert srst_n=0 for one edge concurrent with we=1/re_a=1 -> that write is lost, rvalid_a=0, and all addresses read 0 afterwards.
